// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT peak detector.
// The FFT_PEAK_THRESHOLD_EN build option is handled in the interface and top files.
package fft_pkg;

  localparam int DATA_W   = 16;
  localparam int N_POINTS = 64;
  localparam int IDX_W    = $clog2(N_POINTS);

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef logic [2*DATA_W:0] mag_t;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} peak_state_t;

endpackage

// File: rtl/fft_peak_detect_if.sv
// Bin stream, control and result bundle of the FFT peak detector.
// FFT_PEAK_THRESHOLD_EN adds the threshold input and the peak_found result.
interface fft_peak_detect_if #(
  parameter int DATA_W   = 16,
  parameter int N_POINTS = 64
);
  localparam int IDX_W = $clog2(N_POINTS);

  logic                start;
  logic                bin_valid;
  logic [2*DATA_W-1:0] bin_data;
  logic                bin_ready;
  logic                busy;
  logic                peak_valid;
  logic [IDX_W-1:0]    peak_idx;
  logic [2*DATA_W:0]   peak_mag;
`ifdef FFT_PEAK_THRESHOLD_EN
  logic [2*DATA_W:0]   threshold;
  logic                peak_found;

  modport master (
    output start, bin_valid, bin_data, threshold,
    input  bin_ready, busy, peak_valid, peak_idx, peak_mag, peak_found
  );
  modport slave (
    input  start, bin_valid, bin_data, threshold,
    output bin_ready, busy, peak_valid, peak_idx, peak_mag, peak_found
  );
`else
  modport master (
    output start, bin_valid, bin_data,
    input  bin_ready, busy, peak_valid, peak_idx, peak_mag
  );
  modport slave (
    input  start, bin_valid, bin_data,
    output bin_ready, busy, peak_valid, peak_idx, peak_mag
  );
`endif

endinterface

// File: rtl/fft_mag_sq.sv
// Three-stage squared-magnitude pipe (register, square, sum) with the bin
// tag (valid, in-window flag, index) travelling alongside the data.
module fft_mag_sq import fft_pkg::*; #(
  parameter int DATA_W   = fft_pkg::DATA_W,
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int BIN_LO   = 1,
  parameter int BIN_HI   = 31,
  localparam int IDX_W   = $clog2(N_POINTS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [2*DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]    in_idx,
  output logic                out_valid,
  output logic                out_in_window,
  output logic [IDX_W-1:0]    out_idx,
  output logic [2*DATA_W:0]   out_mag,
  output logic                pipe_active
);

  localparam int TAG_W = IDX_W + 2;
  localparam logic [IDX_W-1:0] LO_IDX = IDX_W'(BIN_LO);
  localparam logic [IDX_W-1:0] HI_IDX = IDX_W'(BIN_HI);

  logic [TAG_W-1:0]         tag_in;
  logic [TAG_W-1:0]         tag_reg [3];
  logic signed [DATA_W-1:0] re_reg, im_reg;
  logic [2*DATA_W-1:0]      re_sq_reg, im_sq_reg;
  logic [2*DATA_W:0]        mag_reg;

  assign tag_in = {in_valid, (in_idx >= LO_IDX) && (in_idx <= HI_IDX), in_idx};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!reset) tag_reg[0] <= '0;
          else        tag_reg[0] <= tag_in;
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (!reset) tag_reg[gi] <= '0;
          else        tag_reg[gi] <= tag_reg[gi-1];
        end
      end
    end
  endgenerate

  // Squares are non-negative, so the sum is formed unsigned one bit wider.
  always_ff @(posedge clk) begin
    re_reg    <= in_data[2*DATA_W-1:DATA_W];
    im_reg    <= in_data[DATA_W-1:0];
    re_sq_reg <= re_reg * re_reg;
    im_sq_reg <= im_reg * im_reg;
    mag_reg   <= {1'b0, re_sq_reg} + {1'b0, im_sq_reg};
  end

  assign out_valid     = tag_reg[2][TAG_W-1];
  assign out_in_window = tag_reg[2][TAG_W-2];
  assign out_idx       = tag_reg[2][IDX_W-1:0];
  assign out_mag       = mag_reg;
  assign pipe_active   = tag_reg[0][TAG_W-1] | tag_reg[1][TAG_W-1] | tag_reg[2][TAG_W-1];

endmodule

// File: rtl/fft_peak_detect.sv
// Frame controller and running-maximum stage of the FFT peak detector.
// Optional FFT_PEAK_THRESHOLD_EN gates the reported peak with a latched threshold.
module fft_peak_detect import fft_pkg::*; #(
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int DATA_W   = fft_pkg::DATA_W,
  parameter int BIN_LO   = 1,
  parameter int BIN_HI   = 31
) (
  input  logic            clk,
  input  logic            reset,
  fft_peak_detect_if.slave bus
);

  localparam int IDX_W = $clog2(N_POINTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);
  localparam logic [IDX_W-1:0] LO_IDX   = IDX_W'(BIN_LO);

  peak_state_t       state_reg;
  logic [IDX_W-1:0]  cnt_reg, max_idx_reg, peak_idx_reg;
  logic [2*DATA_W:0] max_mag_reg, peak_mag_reg;
  logic              bin_ready_reg, busy_reg, peak_valid_reg, s4_valid_reg;
`ifdef FFT_PEAK_THRESHOLD_EN
  logic [2*DATA_W:0] threshold_reg;
  logic              peak_found_reg;
`endif

  logic              accept;
  logic              s3_valid, s3_in_window, pipe_active;
  logic [IDX_W-1:0]  s3_idx;
  logic [2*DATA_W:0] s3_mag;

  assign accept = bus.bin_valid && bin_ready_reg;

  fft_mag_sq #(
    .DATA_W  (DATA_W),
    .N_POINTS(N_POINTS),
    .BIN_LO  (BIN_LO),
    .BIN_HI  (BIN_HI)
  ) u_mag_sq (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (accept),
    .in_data      (bus.bin_data),
    .in_idx       (cnt_reg),
    .out_valid    (s3_valid),
    .out_in_window(s3_in_window),
    .out_idx      (s3_idx),
    .out_mag      (s3_mag),
    .pipe_active  (pipe_active)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      max_idx_reg    <= '0;
      max_mag_reg    <= '0;
      peak_idx_reg   <= '0;
      peak_mag_reg   <= '0;
      bin_ready_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      peak_valid_reg <= 1'b0;
      s4_valid_reg   <= 1'b0;
`ifdef FFT_PEAK_THRESHOLD_EN
      threshold_reg  <= '0;
      peak_found_reg <= 1'b0;
`endif
    end else begin
      peak_valid_reg <= 1'b0;
      s4_valid_reg   <= s3_valid;
      // Strict greater-than keeps the lowest index on ties.
      if (s3_valid && s3_in_window && (s3_mag > max_mag_reg)) begin
        max_mag_reg <= s3_mag;
        max_idx_reg <= s3_idx;
      end
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg     <= COLLECT;
            cnt_reg       <= '0;
            max_mag_reg   <= '0;
            max_idx_reg   <= LO_IDX;
            busy_reg      <= 1'b1;
            bin_ready_reg <= 1'b1;
`ifdef FFT_PEAK_THRESHOLD_EN
            threshold_reg <= bus.threshold;
`endif
          end
        end
        COLLECT: begin
          if (accept) begin
            cnt_reg <= cnt_reg + IDX_W'(1);
            if (cnt_reg == LAST_IDX) begin
              bin_ready_reg <= 1'b0;
              state_reg     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!pipe_active && !s4_valid_reg) begin
            state_reg      <= DONE;
            peak_valid_reg <= 1'b1;
            busy_reg       <= 1'b0;
`ifdef FFT_PEAK_THRESHOLD_EN
            if (max_mag_reg >= threshold_reg) begin
              peak_found_reg <= 1'b1;
              peak_idx_reg   <= max_idx_reg;
              peak_mag_reg   <= max_mag_reg;
            end else begin
              peak_found_reg <= 1'b0;
              peak_idx_reg   <= '0;
              peak_mag_reg   <= '0;
            end
`else
            peak_idx_reg   <= max_idx_reg;
            peak_mag_reg   <= max_mag_reg;
`endif
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.bin_ready  = bin_ready_reg;
  assign bus.busy       = busy_reg;
  assign bus.peak_valid = peak_valid_reg;
  assign bus.peak_idx   = peak_idx_reg;
  assign bus.peak_mag   = peak_mag_reg;
`ifdef FFT_PEAK_THRESHOLD_EN
  assign bus.peak_found = peak_found_reg;
`endif

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect: directed frames plus random frames
// compared every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_fft_peak_detect;
  import fft_pkg::*;

  localparam int N   = 64;
  localparam int BLO = 1;
  localparam int BHI = 31;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft_peak_detect_if #(.DATA_W(16), .N_POINTS(N)) bus ();

  fft_peak_detect #(.N_POINTS(N), .DATA_W(16), .BIN_LO(BLO), .BIN_HI(BHI)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc = 0;
  int frame_no = 0;

  cplx_t frame_in [N];
  cplx_t m_frame [N];

  // Reference model state (frame level, not cycle-by-cycle logic)
  bit     m_idle = 1'b1, m_ready = 1'b0, m_busy = 1'b0;
  int     m_cnt = 0;
  int     exp_pv_cyc = -10;
  int     exp_idx = 0, pend_idx = 0;
  longint exp_mag = 0, pend_mag = 0;
  bit     exp_found = 1'b0, pend_found = 1'b0;
  longint m_thr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic void ref_peak(input longint thr, output int idx, output longint mag,
                                   output bit found);
    longint best = 0;
    int bi = BLO;
    for (int i = BLO; i <= BHI; i++) begin
      longint m = longint'(m_frame[i].re) * longint'(m_frame[i].re)
                + longint'(m_frame[i].im) * longint'(m_frame[i].im);
      if (m > best) begin
        best = m;
        bi = i;
      end
    end
    idx = bi;
    mag = best;
    found = 1'b1;
`ifdef FFT_PEAK_THRESHOLD_EN
    found = (best >= thr);
    if (!found) begin
      idx = 0;
      mag = 0;
    end
`endif
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_idle = 1'b1; m_ready = 1'b0; m_busy = 1'b0; m_cnt = 0;
      exp_pv_cyc = -10; exp_idx = 0; exp_mag = 0; exp_found = 1'b0;
    end else begin
      if (cyc == exp_pv_cyc) begin
        exp_idx = pend_idx; exp_mag = pend_mag; exp_found = pend_found; m_busy = 1'b0;
      end
      if (m_ready && bus.bin_valid) begin
        m_frame[m_cnt] = bus.bin_data;
        m_cnt++;
        if (m_cnt == N) begin
          m_ready = 1'b0;
          exp_pv_cyc = cyc + 5;
          ref_peak(m_thr, pend_idx, pend_mag, pend_found);
        end
      end else if (m_idle && bus.start) begin
        m_idle = 1'b0; m_ready = 1'b1; m_busy = 1'b1; m_cnt = 0;
`ifdef FFT_PEAK_THRESHOLD_EN
        m_thr = longint'(bus.threshold);
`endif
      end
      if (cyc == exp_pv_cyc + 1) m_idle = 1'b1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("peak_valid", 64'(bus.peak_valid), 64'(cyc == exp_pv_cyc));
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("bin_ready", 64'(bus.bin_ready), 64'(m_ready));
      check("peak_idx", 64'(bus.peak_idx), 64'(exp_idx));
      check("peak_mag", 64'(bus.peak_mag), 64'(exp_mag));
`ifdef FFT_PEAK_THRESHOLD_EN
      check("peak_found", 64'(bus.peak_found), 64'(exp_found));
`endif
    end
  end

  task automatic clear_frame();
    for (int i = 0; i < N; i++) frame_in[i] = '0;
  endtask

  task automatic set_bin(input int i, input int re, input int im);
    frame_in[i].re = 16'(re);
    frame_in[i].im = 16'(im);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // mode 0: contiguous, 1: valid every other cycle, 2: random gaps
  task automatic send_frame(input int mode, input int max_bins, input int start_at);
    int k = 0;
    int t = 0;
    bit acc;
    while (k < max_bins && t < 2000) begin
      case (mode)
        0:       bus.bin_valid = 1'b1;
        1:       bus.bin_valid = (t % 2 == 0);
        default: bus.bin_valid = ($urandom_range(3) != 0);
      endcase
      bus.bin_data = frame_in[k];
      bus.start = (t == start_at);
      @(negedge clk);
      acc = bus.bin_valid && bus.bin_ready;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        last_acc = cyc;
      end
      t++;
    end
    bus.bin_valid = 1'b0;
    bus.start = 1'b0;
    check("send_accepted_bins", 64'(k), 64'(max_bins));
  endtask

  task automatic wait_peak(output int idx, output longint mag, output int lat);
    int t = 0;
    bit seen = 1'b0;
    idx = -1; mag = -1; lat = -1;
    while (!seen && t < 30) begin
      @(negedge clk);
      if (bus.peak_valid) begin
        seen = 1'b1;
        idx = int'(bus.peak_idx);
        mag = longint'(bus.peak_mag);
        lat = cyc - last_acc;
      end
      t++;
    end
    check("peak_valid_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    frame_no++;
    $display("frame %0d: peak_idx=%0d peak_mag=%0d latency=%0d", frame_no, idx, mag, lat);
  endtask

  int     r_idx, r_lat, s_idx;
  longint r_mag, s_mag;

  initial begin
    bus.start = 1'b0; bus.bin_valid = 1'b0; bus.bin_data = '0;
`ifdef FFT_PEAK_THRESHOLD_EN
    bus.threshold = '0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_peak_idx", 64'(bus.peak_idx), 64'd0);
    check("reset_peak_mag", 64'(bus.peak_mag), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;

    // Reset mid-frame
    clear_frame();
    for (int i = 0; i < N; i++) frame_in[i] = cplx_t'($urandom());
    pulse_start();
    send_frame(0, 10, -1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midreset_busy", 64'(bus.busy), 64'd0);
    check("midreset_ready", 64'(bus.bin_ready), 64'd0);
    check("midreset_valid", 64'(bus.peak_valid), 64'd0);
    repeat (8) @(posedge clk);
    #1;

    // Single tone after reset
    clear_frame();
    set_bin(5, 1000, 0);
    pulse_start();
    send_frame(0, N, -1);
    wait_peak(r_idx, r_mag, r_lat);
    check("tone_idx", 64'(r_idx), 64'd5);
    check("tone_mag", 64'(r_mag), 64'd1000000);
    check("tone_latency", 64'(r_lat), 64'd5);
    check("model_tone_idx", 64'(exp_idx), 64'd5);

    // Out-of-window maxima including the 2^31 case
    clear_frame();
    set_bin(0, 32767, 32767);
    set_bin(40, -32768, -32768);
    set_bin(7, 3, 4);
    pulse_start();
    send_frame(0, N, -1);
    wait_peak(r_idx, r_mag, r_lat);
    check("window_idx", 64'(r_idx), 64'd7);
    check("window_mag", 64'(r_mag), 64'd25);

    // Tie: lowest index wins
    clear_frame();
    set_bin(9, 0, -300);
    set_bin(12, 0, -300);
    pulse_start();
    send_frame(0, N, -1);
    wait_peak(r_idx, r_mag, r_lat);
    check("tie_idx", 64'(r_idx), 64'd9);
    check("tie_mag", 64'(r_mag), 64'd90000);
    check("model_tie_mag", 64'(exp_mag), 64'd90000);

    // Bubbles plus ignored mid-frame start, then the same frame contiguous
    for (int i = 0; i < N; i++) begin
      int v = int'($urandom_range(0, 4000)) - 2000;
      set_bin(i, v, int'($urandom_range(0, 600)) - 300);
    end
    pulse_start();
    send_frame(1, N, 41);
    wait_peak(r_idx, r_mag, r_lat);
    pulse_start();
    send_frame(0, N, -1);
    wait_peak(s_idx, s_mag, r_lat);
    check("bubble_vs_contig_idx", 64'(r_idx), 64'(s_idx));
    check("bubble_vs_contig_mag", 64'(r_mag), 64'(s_mag));

    // Random frames with random gaps
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(2))
          0: frame_in[i] = '0;
          1: set_bin(i, int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100);
          default: frame_in[i] = cplx_t'($urandom());
        endcase
      end
      frame_in[$urandom_range(BLO, BHI)] = frame_in[$urandom_range(BLO, BHI)];
      pulse_start();
      send_frame(2, N, -1);
      wait_peak(r_idx, r_mag, r_lat);
    end

`ifdef FFT_PEAK_THRESHOLD_EN
    clear_frame();
    set_bin(5, 300, 0);
    bus.threshold = 33'd100000;
    pulse_start();
    bus.threshold = '0;
    send_frame(0, N, -1);
    wait_peak(r_idx, r_mag, r_lat);
    check("thr_low_found", 64'(bus.peak_found), 64'd0);
    check("thr_low_idx", 64'(r_idx), 64'd0);
    check("thr_low_mag", 64'(r_mag), 64'd0);

    clear_frame();
    set_bin(3, 400, 0);
    bus.threshold = 33'd100000;
    pulse_start();
    bus.threshold = 33'h1_FFFF_FFFF;
    send_frame(0, N, -1);
    wait_peak(r_idx, r_mag, r_lat);
    check("thr_high_found", 64'(bus.peak_found), 64'd1);
    check("thr_high_idx", 64'(r_idx), 64'd3);
    check("thr_high_mag", 64'(r_mag), 64'd160000);
`endif

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Downstream consumer of the 64-point FFT controller's output stream.
- Accepts one frame of N complex bins, one 32-bit word per bin: {re[31:16], im[15:0]}, both two's complement.
- Computes squared magnitude per bin in a pipeline and reports the index and magnitude of the largest bin within a programmable bin window.
- The result feeds the output buffer as a compact dominant-frequency summary.

Parameters:
- N_POINTS, 64, bins per frame; power of two.
- DATA_W, 16, width of the re and im fields.
- BIN_LO, 1, lowest bin index eligible for the peak; the default skips DC.
- BIN_HI, 31, highest eligible bin index (N_POINTS/2-1); must satisfy BIN_LO <= BIN_HI < N_POINTS.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that arms the block for a new frame.
- bin_valid  in  1  bin_data is valid this cycle.
- bin_data  in  2*DATA_W  {re, im}, signed.
- bin_ready  out  1  block accepts a bin this cycle.
- busy  out  1  high from accepted start until peak_valid.
- peak_valid  out  1  one-cycle pulse; the result is valid.
- peak_idx  out  log2(N_POINTS)  index of the maximum bin.
- peak_mag  out  2*DATA_W+1  re^2+im^2 of the maximum bin, unsigned.

Behaviour:
- Reset (reset=0 at posedge clk):
  - state=IDLE.
  - bin_ready, busy and peak_valid = 0.
  - peak_idx and peak_mag = 0.
  - Internal bin counter, running max and pipeline valid bits are cleared.
  - Reset takes effect mid-frame with no output pulse.
- States: IDLE, COLLECT, DRAIN, DONE.
  - IDLE -> COLLECT on start. The counter and running max (max_mag=0, max_idx=BIN_LO) are cleared, busy=1.
  - COLLECT: bin_ready=1. A bin is accepted on bin_valid && bin_ready. It is tagged with the counter value, and the counter increments.
  - COLLECT -> DRAIN when bin N_POINTS-1 is accepted; bin_ready=0 from the next cycle.
  - DRAIN -> DONE once every pipeline valid bit is clear.
  - DONE: peak_valid=1 for exactly one cycle; peak_idx/peak_mag load from the running max; busy=0; the next state is IDLE.
  - peak_idx/peak_mag hold their value until the next DONE or reset.
- start outside IDLE is ignored. A start on the same cycle as peak_valid is also ignored.
- bin_valid outside COLLECT is ignored and no bin is consumed.
- Pipeline (one bin per cycle, no stalls inside the pipe):
  - S1: register re, im, idx and an in_window flag (BIN_LO <= idx <= BIN_HI).
  - S2: signed products re*re and im*im (2*DATA_W bits each).
  - S3: unsigned sum, 2*DATA_W+1 bits with no overflow; -32768^2 * 2 = 2^31 fits.
  - S4: compare-and-update. If in_window && sum > max_mag, then max_mag=sum and max_idx=idx.
- Latency: peak_valid is asserted 5 cycles after the posedge that accepts the last bin.
- Ties: strict greater-than, so the lowest index wins.
- An all-zero frame reports peak_idx=BIN_LO, peak_mag=0.
- Gaps in bin_valid are allowed. The pipe carries bubbles, which have their valid bit clear and never update the max.
- The counter does not wrap within a frame; acceptance stops at N_POINTS bins.

Optional Feature:
- Macro: FFT_PEAK_THRESHOLD_EN.
- When defined:
  - Adds input port `threshold` (2*DATA_W+1 bits) and output port `peak_found` (1 bit).
  - threshold is sampled at start acceptance.
  - At DONE, peak_found = (max_mag >= threshold_latched).
  - If peak_found=0, peak_idx=0 and peak_mag=0.
  - peak_found resets to 0 and holds like peak_idx.
- When undefined: neither port exists, and peak_idx/peak_mag always report the running max.

Decomposition:
- Package fft_pkg:
  - DATA_W, N_POINTS and IDX_W=$clog2(N_POINTS).
  - typedef cplx_t: packed struct {logic signed [DATA_W-1:0] re, im}.
  - typedef mag_t: logic [2*DATA_W:0].
  - enum peak_state_t {IDLE, COLLECT, DRAIN, DONE}.
- One sub-module: fft_mag_sq (stages S1–S3, valid/idx/in_window pass-through, 3-cycle latency).
- The FSM and the compare stage (S4) stay in fft_peak_detect.

Test Plan:
- Reset mid-frame: after 10 bins, reset=0 for 1 cycle -> all outputs 0, no peak_valid; a new start followed by 64 bins works normally.
- Single tone: bin 5 = {re=1000, im=0}, all other bins 0 -> peak_idx=5, peak_mag=1000000, peak_valid exactly 5 cycles after bin 63 is accepted.
- Out-of-window max: bin 0 = {32767, 32767}, bin 40 = {-32768, -32768}, bin 7 = {3, 4} -> peak_idx=7, peak_mag=25. This exercises both window limits and the 2^31 width case, which must not contribute.
- Tie: bins 9 and 12 both = {0, -300} -> peak_idx=9, peak_mag=90000.
- Backpressure and bubbles: bin_valid toggles every other cycle, plus a start pulse mid-COLLECT -> the start is ignored, and the result equals the contiguous-stream result.
- FFT_PEAK_THRESHOLD_EN:
  - threshold=100000 with a single tone {300, 0} -> peak_found=0, peak_idx=0, peak_mag=0.
  - Same threshold with a tone {400, 0} at bin 3 -> peak_found=1, peak_idx=3, peak_mag=160000.
